// File: rtl/hover_controller.sv
// Debounced push-button hover cursor over a 4x3 product grid or a 12-slot basket list.
// Define HOVER_WRAP_EN to make edge moves wrap around; otherwise they saturate.
module hover_controller #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_WIDTH       = 20
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        BTN_UP,
  input  logic        BTN_DOWN,
  input  logic        BTN_LEFT,
  input  logic        BTN_RIGHT,
  input  logic        BTN_SELECT,
  input  logic        SW2,
  output logic [11:0] HighlightedProductList,
  output logic [3:0]  CursorID,
  output logic        AddPulse,
  output logic        RemovePulse,
  output logic [1:0]  dbg_state
);

`ifdef HOVER_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DB_PRESS, HELD, DB_RELEASE} state_t;
  // Key codes double as bit positions in the synced, active-high button vector.
  typedef enum logic [2:0] {K_RIGHT, K_LEFT, K_DOWN, K_UP, K_SEL} key_t;

  logic [4:0]           btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;
  logic                 sw2_s1_q, sw2_s1_d, sw2_s2_q, sw2_s2_d, sw2_prev_q, sw2_prev_d;
  state_t               state_q, state_d;
  key_t                 key_q, key_d, win_key;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [3:0]           cursor_q, cursor_d;
  logic [11:0]          list_q, list_d;
  logic                 add_q, add_d, rem_q, rem_d;

  logic [4:0] pressed;
  logic       any_press, event_fire, sw2_toggle;
  logic [1:0] row, col;

  always_comb begin
    btn_s1_d   = {BTN_SELECT, BTN_UP, BTN_DOWN, BTN_LEFT, BTN_RIGHT};
    btn_s2_d   = btn_s1_q;
    sw2_s1_d   = SW2;
    sw2_s2_d   = sw2_s1_q;
    sw2_prev_d = sw2_s2_q;
    pressed    = ~btn_s2_q;
    any_press  = |pressed;
    sw2_toggle = sw2_s2_q != sw2_prev_q;
  end

  always_comb begin
    win_key = K_RIGHT;
    if (pressed[K_SEL])       win_key = K_SEL;
    else if (pressed[K_UP])   win_key = K_UP;
    else if (pressed[K_DOWN]) win_key = K_DOWN;
    else if (pressed[K_LEFT]) win_key = K_LEFT;
  end

  // One counter serves both the press and the release debounce windows.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    key_d      = key_q;
    event_fire = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_press) begin
          key_d   = win_key;
          cnt_d   = '0;
          state_d = DB_PRESS;
        end
      end
      DB_PRESS: begin
        if (!pressed[key_q]) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          event_fire = 1'b1;
          state_d    = HELD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (!any_press) begin
          cnt_d   = '0;
          state_d = DB_RELEASE;
        end
      end
      DB_RELEASE: begin
        if (any_press) begin
          state_d = HELD;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // AddPulse/RemovePulse are single-cycle strobes with no ready: the consumer
  // must act on CursorID in the same cycle the strobe is high.
  always_comb begin
    row      = cursor_q[3:2];
    col      = cursor_q[1:0];
    cursor_d = cursor_q;
    add_d    = 1'b0;
    rem_d    = 1'b0;
    if (sw2_toggle) begin
      cursor_d = 4'd0;
    end else if (event_fire) begin
      if (!sw2_s2_q) begin
        case (key_q)
          K_SEL:   add_d = 1'b1;
          K_UP:    if (row != 2'd0) cursor_d = cursor_q - 4'd4;
                   else if (WRAP_EN) cursor_d = {2'd2, col};
          K_DOWN:  if (row != 2'd2) cursor_d = cursor_q + 4'd4;
                   else if (WRAP_EN) cursor_d = {2'd0, col};
          K_LEFT:  if (col != 2'd0) cursor_d = cursor_q - 4'd1;
                   else if (WRAP_EN) cursor_d = {row, 2'd3};
          K_RIGHT: if (col != 2'd3) cursor_d = cursor_q + 4'd1;
                   else if (WRAP_EN) cursor_d = {row, 2'd0};
          default: cursor_d = cursor_q;
        endcase
      end else begin
        case (key_q)
          K_SEL:   rem_d = 1'b1;
          K_UP:    if (cursor_q != 4'd0) cursor_d = cursor_q - 4'd1;
                   else if (WRAP_EN) cursor_d = 4'd11;
          K_DOWN:  if (cursor_q != 4'd11) cursor_d = cursor_q + 4'd1;
                   else if (WRAP_EN) cursor_d = 4'd0;
          default: cursor_d = cursor_q;
        endcase
      end
    end
    list_d = 12'd1 << cursor_d;
  end

  // Button synchronizers reset to the released (high) level so reset never looks like a press.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      btn_s1_q   <= 5'h1f;
      btn_s2_q   <= 5'h1f;
      sw2_s1_q   <= 1'b0;
      sw2_s2_q   <= 1'b0;
      sw2_prev_q <= 1'b0;
      state_q    <= IDLE;
      key_q      <= K_RIGHT;
      cnt_q      <= '0;
      cursor_q   <= 4'd0;
      list_q     <= 12'h001;
      add_q      <= 1'b0;
      rem_q      <= 1'b0;
    end else begin
      btn_s1_q   <= btn_s1_d;
      btn_s2_q   <= btn_s2_d;
      sw2_s1_q   <= sw2_s1_d;
      sw2_s2_q   <= sw2_s2_d;
      sw2_prev_q <= sw2_prev_d;
      state_q    <= state_d;
      key_q      <= key_d;
      cnt_q      <= cnt_d;
      cursor_q   <= cursor_d;
      list_q     <= list_d;
      add_q      <= add_d;
      rem_q      <= rem_d;
    end
  end

  assign HighlightedProductList = list_q;
  assign CursorID               = cursor_q;
  assign AddPulse               = add_q;
  assign RemovePulse            = rem_q;
  assign dbg_state              = state_q;

endmodule

// File: tb/tb_hover_controller.sv
// Scoreboard bench for hover_controller with DEBOUNCE_CYCLES=4; expected events carry their due cycle.
module tb_hover_controller;
  localparam int DB  = 4;
  localparam int LAT = DB + 3;
  localparam logic [4:0] M_UP = 5'b00001, M_DN = 5'b00010, M_LF = 5'b00100,
                         M_RT = 5'b01000, M_SEL = 5'b10000;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        BTN_UP = 1'b1, BTN_DOWN = 1'b1, BTN_LEFT = 1'b1, BTN_RIGHT = 1'b1, BTN_SELECT = 1'b1;
  logic        SW2 = 1'b0;
  logic [11:0] HighlightedProductList;
  logic [3:0]  CursorID;
  logic        AddPulse, RemovePulse;
  logic [1:0]  dbg_state;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [3:0]  track_cur = 4'd0;
  logic [3:0]  prev_cur = 4'd0;
  logic [21:0] exp_q[$];
  logic [21:0] mon_e;

  hover_controller #(.DEBOUNCE_CYCLES(DB), .CNT_WIDTH(3)) dut (
    .CLK(CLK), .RST(RST),
    .BTN_UP(BTN_UP), .BTN_DOWN(BTN_DOWN), .BTN_LEFT(BTN_LEFT),
    .BTN_RIGHT(BTN_RIGHT), .BTN_SELECT(BTN_SELECT), .SW2(SW2),
    .HighlightedProductList(HighlightedProductList), .CursorID(CursorID),
    .AddPulse(AddPulse), .RemovePulse(RemovePulse), .dbg_state(dbg_state)
  );

  // clock / cycle counter
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, got, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [4:0] mask);
    {BTN_SELECT, BTN_RIGHT, BTN_LEFT, BTN_DOWN, BTN_UP} = ~mask;
  endtask

  task automatic expect_ev(input int at, input logic [3:0] cur, input logic add, input logic rem);
    exp_q.push_back({16'(at), rem, add, cur});
  endtask

  // Press mask for 10 cycles then idle 8; an event is expected when the cursor or a pulse changes.
  task automatic step(input logic [4:0] mask, input logic [3:0] exp_cur, input logic exp_add,
                      input logic exp_rem);
    int k;
    k = cyc;
    if (exp_cur != track_cur || exp_add || exp_rem) expect_ev(k + LAT, exp_cur, exp_add, exp_rem);
    track_cur = exp_cur;
    drive(mask);
    wait_cyc(10);
    drive(5'b0);
    wait_cyc(8);
  endtask

  task automatic set_sw2(input logic v);
    int j;
    j = cyc;
    if (track_cur != 4'd0) expect_ev(j + 3, 4'd0, 1'b0, 1'b0);
    track_cur = 4'd0;
    SW2 = v;
    wait_cyc(6);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cursor"}, CursorID, 0);
    check({tag, "_list"}, HighlightedProductList, 12'h001);
    check({tag, "_add"}, AddPulse, 0);
    check({tag, "_rem"}, RemovePulse, 0);
  endtask

  // monitor: invariants every cycle, scoreboard pop whenever the outputs show an event
  always @(negedge CLK) begin
    if (RST) begin
      prev_cur = CursorID;
    end else begin
      check("onehot", HighlightedProductList, 12'b1 << CursorID);
      check("cursor_range", int'(CursorID > 4'd11), 0);
      check("pulse_exclusive", int'(AddPulse & RemovePulse), 0);
      if (CursorID != prev_cur || AddPulse || RemovePulse) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: cursor %0d add %0b rem %0b at cycle %0d, required no event",
                   CursorID, AddPulse, RemovePulse, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check("ev_cursor", CursorID, mon_e[3:0]);
          check("ev_list", HighlightedProductList, 12'b1 << mon_e[3:0]);
          check("ev_add", AddPulse, mon_e[4]);
          check("ev_rem", RemovePulse, mon_e[5]);
          check("ev_cycle", cyc[15:0], mon_e[21:6]);
        end
      end
      prev_cur = CursorID;
    end
  end

  initial begin : stim
    int k;
    drive(5'b0);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_reset_vals("reset");
    @(posedge CLK);
    #1;
    RST = 1'b0;
    wait_cyc(3);

    // 1: single clean press
    step(M_RT, 4'd1, 1'b0, 1'b0);

    // 2: bounce gives nothing; a glitch during release debounce gives no second event
    drive(M_RT); wait_cyc(2); drive(5'b0); wait_cyc(1);
    drive(M_RT); wait_cyc(2); drive(5'b0); wait_cyc(10);
    k = cyc;
    expect_ev(k + LAT, 4'd2, 1'b0, 1'b0);
    track_cur = 4'd2;
    drive(M_RT); wait_cyc(10); drive(5'b0); wait_cyc(3);
    drive(M_RT); wait_cyc(1); drive(5'b0); wait_cyc(12);

    // 3: grid edges
    step(M_RT, 4'd3, 1'b0, 1'b0);
`ifdef HOVER_WRAP_EN
    step(M_RT, 4'd0, 1'b0, 1'b0);
    step(M_DN, 4'd4, 1'b0, 1'b0);
    step(M_DN, 4'd8, 1'b0, 1'b0);
    step(M_RT, 4'd9, 1'b0, 1'b0);
    step(M_DN, 4'd1, 1'b0, 1'b0);
    step(M_DN, 4'd5, 1'b0, 1'b0);
    step(M_RT, 4'd6, 1'b0, 1'b0);
    step(M_UP, 4'd2, 1'b0, 1'b0);
    step(M_UP, 4'd10, 1'b0, 1'b0);
`else
    step(M_RT, 4'd3, 1'b0, 1'b0);
    step(M_DN, 4'd7, 1'b0, 1'b0);
    step(M_DN, 4'd11, 1'b0, 1'b0);
    step(M_LF, 4'd10, 1'b0, 1'b0);
    step(M_LF, 4'd9, 1'b0, 1'b0);
    step(M_DN, 4'd9, 1'b0, 1'b0);
    step(M_UP, 4'd5, 1'b0, 1'b0);
    step(M_RT, 4'd6, 1'b0, 1'b0);
    step(M_UP, 4'd2, 1'b0, 1'b0);
    step(M_UP, 4'd2, 1'b0, 1'b0);
`endif

    // 4: basket mode
    set_sw2(1'b1);
    for (int i = 1; i <= 11; i++) step(M_DN, 4'(i), 1'b0, 1'b0);
`ifdef HOVER_WRAP_EN
    step(M_DN, 4'd0, 1'b0, 1'b0);
    step(M_LF, 4'd0, 1'b0, 1'b0);
    step(M_RT, 4'd0, 1'b0, 1'b0);
    step(M_SEL, 4'd0, 1'b0, 1'b1);
    step(M_UP, 4'd11, 1'b0, 1'b0);
`else
    step(M_DN, 4'd11, 1'b0, 1'b0);
    step(M_LF, 4'd11, 1'b0, 1'b0);
    step(M_RT, 4'd11, 1'b0, 1'b0);
    step(M_SEL, 4'd11, 1'b0, 1'b1);
    step(M_UP, 4'd10, 1'b0, 1'b0);
`endif

    // 5: SELECT beats LEFT; SW2 toggle in the event cycle drops a SELECT
    set_sw2(1'b0);
    step(M_DN, 4'd4, 1'b0, 1'b0);
    step(M_RT, 4'd5, 1'b0, 1'b0);
    step(M_SEL | M_LF, 4'd5, 1'b1, 1'b0);
    k = cyc;
    expect_ev(k + LAT, 4'd0, 1'b0, 1'b0);
    track_cur = 4'd0;
    drive(M_SEL); wait_cyc(DB);
    SW2 = 1'b1; wait_cyc(10 - DB);
    drive(5'b0); wait_cyc(8);

    // 6: reset in the middle of a press debounce, key held through reset
    step(M_DN, 4'd1, 1'b0, 1'b0);
`ifdef HOVER_WRAP_EN
    drive(M_UP);
`else
    drive(M_DN);
`endif
    wait_cyc(4);
    RST = 1'b1;
    @(negedge CLK);
    check_reset_vals("midreset");
    @(posedge CLK);
    #1;
    RST = 1'b0;
    k = cyc;
`ifdef HOVER_WRAP_EN
    expect_ev(k + LAT, 4'd11, 1'b0, 1'b0);
    track_cur = 4'd11;
`else
    expect_ev(k + LAT, 4'd1, 1'b0, 1'b0);
    track_cur = 4'd1;
`endif
    wait_cyc(10);
    drive(5'b0);
    wait_cyc(10);

    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
